// File: rtl/pipe_control_if.sv
// Hazard/sequencing bus between the pipeline datapath and pipe_control.
// The master side is the pipeline; the slave side is the controller.
interface pipe_control_if;
    logic [4:0] SrcAID;
    logic       UsaAID;
    logic [4:0] SrcBID;
    logic       UsaBID;
    logic       EsVecID;
    logic       EsLoadDE;
    logic       WriteRegDE;
    logic [4:0] DirWriteDE;
    logic       SaltoEX;
    logic       StallExt;

    logic       StallPC;
    logic       StallFD;
    logic       StallDE;
    logic       FlushFD;
    logic       BurbujaDE;
    logic [4:0] VecIdx;
    logic [2:0] VecLanes;
    logic       VecValido;
    logic       VecUltimo;
    logic       Ocupado;

    modport master (
        output SrcAID, UsaAID, SrcBID, UsaBID, EsVecID,
               EsLoadDE, WriteRegDE, DirWriteDE, SaltoEX, StallExt,
        input  StallPC, StallFD, StallDE, FlushFD, BurbujaDE,
               VecIdx, VecLanes, VecValido, VecUltimo, Ocupado
    );

    modport slave (
        input  SrcAID, UsaAID, SrcBID, UsaBID, EsVecID,
               EsLoadDE, WriteRegDE, DirWriteDE, SaltoEX, StallExt,
        output StallPC, StallFD, StallDE, FlushFD, BurbujaDE,
               VecIdx, VecLanes, VecValido, VecUltimo, Ocupado
    );
endinterface

// File: rtl/pipe_control.sv
// Hazard and sequencing controller for the five-stage pipeline: load-use
// interlocks, branch flushes, external stalls and vector lane-group issue.
module pipe_control #(
    parameter int unsigned VEC_LEN = 25,
    parameter int unsigned LANES   = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    pipe_control_if.slave  bus
);

    localparam int unsigned G     = (VEC_LEN + LANES - 1) / LANES;
    localparam int unsigned CNT_W = (G > 1) ? $clog2(G) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(G - 1);

    typedef enum logic {RUN, VEC} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic        hazard_c;
    logic [31:0] idx_full;
    logic [31:0] rem;
    logic [4:0]  vec_idx;
    logic [2:0]  vec_lanes;

    logic stall_pc, stall_fd, stall_de, flush_fd, burbuja_de;
    logic vec_valido, vec_ultimo, ocupado;

    assign hazard_c = bus.EsLoadDE & bus.WriteRegDE & (bus.DirWriteDE != 5'd0) &
                      ((bus.UsaAID & (bus.SrcAID == bus.DirWriteDE)) |
                       (bus.UsaBID & (bus.SrcBID == bus.DirWriteDE)));

    // Group geometry; the final group may be partial when LANES does not divide VEC_LEN.
    assign idx_full  = 32'(cnt_q) * LANES;
    assign rem       = VEC_LEN - idx_full;
    assign vec_idx   = 5'(idx_full);
    assign vec_lanes = (rem < LANES) ? 3'(rem) : 3'(LANES);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        stall_pc   = 1'b0;
        stall_fd   = 1'b0;
        stall_de   = 1'b0;
        flush_fd   = 1'b0;
        burbuja_de = 1'b0;
        vec_valido = 1'b0;
        vec_ultimo = 1'b0;
        ocupado    = (state_q == VEC);

        if (bus.StallExt) begin
            // EX is frozen, so branch and interlock decisions wait for release.
            stall_pc = 1'b1;
            stall_fd = 1'b1;
            stall_de = 1'b1;
            if (state_q == VEC) begin
                vec_valido = 1'b1;
                vec_ultimo = (cnt_q == LAST);
            end
        end else if (bus.SaltoEX) begin
            flush_fd   = 1'b1;
            burbuja_de = 1'b1;
            state_d    = RUN;
            cnt_d      = '0;
        end else if (state_q == RUN) begin
            if (hazard_c) begin
                stall_pc   = 1'b1;
                stall_fd   = 1'b1;
                burbuja_de = 1'b1;
            end else if (bus.EsVecID) begin
                vec_valido = 1'b1;
                if (G > 1) begin
                    stall_pc = 1'b1;
                    stall_fd = 1'b1;
                    state_d  = VEC;
                    cnt_d    = CNT_W'(1);
                end else begin
                    vec_ultimo = 1'b1;
                end
            end
        end else begin
            vec_valido = 1'b1;
            if (cnt_q == LAST) begin
                vec_ultimo = 1'b1;
                state_d    = RUN;
                cnt_d      = '0;
            end else begin
                stall_pc = 1'b1;
                stall_fd = 1'b1;
                cnt_d    = cnt_q + CNT_W'(1);
            end
        end
    end

    // Reset forces every output low immediately, independent of the clock.
    assign bus.StallPC   = rst_n & stall_pc;
    assign bus.StallFD   = rst_n & stall_fd;
    assign bus.StallDE   = rst_n & stall_de;
    assign bus.FlushFD   = rst_n & flush_fd;
    assign bus.BurbujaDE = rst_n & burbuja_de;
    assign bus.VecValido = rst_n & vec_valido;
    assign bus.VecUltimo = rst_n & vec_ultimo;
    assign bus.Ocupado   = rst_n & ocupado;
    assign bus.VecIdx    = rst_n ? vec_idx   : 5'd0;
    assign bus.VecLanes  = rst_n ? vec_lanes : 3'd0;

endmodule

// File: tb/tb_pipe_control.sv
// Directed bench for pipe_control: default geometry (5 lanes) plus a
// 4-lane instance for the partial final group.
module tb_pipe_control;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    pipe_control_if b();
    pipe_control_if b4();

    pipe_control #(.VEC_LEN(25), .LANES(5)) dut  (.clk(clk), .rst_n(rst_n), .bus(b));
    pipe_control #(.VEC_LEN(25), .LANES(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));

    // {StallPC, StallFD, StallDE, FlushFD, BurbujaDE, VecValido, VecUltimo, Ocupado}
    logic [7:0] ctl;
    logic [7:0] ctl4;
    assign ctl  = {b.StallPC, b.StallFD, b.StallDE, b.FlushFD, b.BurbujaDE,
                   b.VecValido, b.VecUltimo, b.Ocupado};
    assign ctl4 = {b4.StallPC, b4.StallFD, b4.StallDE, b4.FlushFD, b4.BurbujaDE,
                   b4.VecValido, b4.VecUltimo, b4.Ocupado};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        b.SrcAID = 5'd0;  b.UsaAID = 1'b0; b.SrcBID = 5'd0; b.UsaBID = 1'b0;
        b.EsVecID = 1'b0; b.EsLoadDE = 1'b0; b.WriteRegDE = 1'b0;
        b.DirWriteDE = 5'd0; b.SaltoEX = 1'b0; b.StallExt = 1'b0;
        b4.SrcAID = 5'd0;  b4.UsaAID = 1'b0; b4.SrcBID = 5'd0; b4.UsaBID = 1'b0;
        b4.EsVecID = 1'b0; b4.EsLoadDE = 1'b0; b4.WriteRegDE = 1'b0;
        b4.DirWriteDE = 5'd0; b4.SaltoEX = 1'b0; b4.StallExt = 1'b0;
    endtask

    // Advance one clock; inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        #2;
        n_checks++;
        if (ctl !== 8'h00) begin
            n_fail++; $display("FAIL reset_ctl: got %b expected %b", ctl, 8'h00);
        end
        n_checks++;
        if (b.VecIdx !== 5'd0 || b.VecLanes !== 3'd0) begin
            n_fail++; $display("FAIL reset_vec: got idx=%0d lanes=%0d expected 0/0", b.VecIdx, b.VecLanes);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (ctl !== 8'h00 || b.VecIdx !== 5'd0 || b.VecLanes !== 3'd5) begin
            n_fail++; $display("FAIL idle_after_reset: got ctl=%b idx=%0d lanes=%0d expected 00000000/0/5",
                               ctl, b.VecIdx, b.VecLanes);
        end
    endtask

    task automatic test_load_use();
        b.EsLoadDE = 1'b1; b.WriteRegDE = 1'b1; b.DirWriteDE = 5'd7;
        b.SrcAID = 5'd7; b.UsaAID = 1'b1;
        #1;
        n_checks++;
        if (ctl !== 8'b1100_1000) begin
            n_fail++; $display("FAIL loaduse_A: got %b expected %b", ctl, 8'b1100_1000);
        end
        tick();
        b.EsLoadDE = 1'b0; b.WriteRegDE = 1'b0;
        #1;
        n_checks++;
        if (ctl !== 8'h00) begin
            n_fail++; $display("FAIL loaduse_one_cycle: got %b expected %b", ctl, 8'h00);
        end
        b.EsLoadDE = 1'b1; b.WriteRegDE = 1'b1; b.DirWriteDE = 5'd0; b.SrcAID = 5'd0;
        #1;
        n_checks++;
        if (ctl !== 8'h00) begin
            n_fail++; $display("FAIL loaduse_r0: got %b expected %b", ctl, 8'h00);
        end
        b.DirWriteDE = 5'd12; b.SrcAID = 5'd3; b.UsaAID = 1'b1;
        b.SrcBID = 5'd12; b.UsaBID = 1'b1;
        #1;
        n_checks++;
        if (ctl !== 8'b1100_1000) begin
            n_fail++; $display("FAIL loaduse_B: got %b expected %b", ctl, 8'b1100_1000);
        end
        b.UsaBID = 1'b0;
        #1;
        n_checks++;
        if (ctl !== 8'h00) begin
            n_fail++; $display("FAIL loaduse_B_unused: got %b expected %b", ctl, 8'h00);
        end
        idle();
        tick();
    endtask

    task automatic test_hazard_vs_vector();
        b.EsLoadDE = 1'b1; b.WriteRegDE = 1'b1; b.DirWriteDE = 5'd9;
        b.SrcAID = 5'd9; b.UsaAID = 1'b1; b.EsVecID = 1'b1;
        #1;
        n_checks++;
        if (ctl !== 8'b1100_1000) begin
            n_fail++; $display("FAIL hazard_wins: got %b expected %b", ctl, 8'b1100_1000);
        end
        tick();
        b.EsLoadDE = 1'b0; b.WriteRegDE = 1'b0;
        #1;
        n_checks++;
        if (ctl !== 8'b1100_0100 || b.VecIdx !== 5'd0) begin
            n_fail++; $display("FAIL vec_after_hazard: got ctl=%b idx=%0d expected 11000100/0", ctl, b.VecIdx);
        end
        idle();
        for (int g = 1; g < 5; g++) tick();
        tick();
        n_checks++;
        if (ctl !== 8'h00) begin
            n_fail++; $display("FAIL vec_after_hazard_done: got %b expected %b", ctl, 8'h00);
        end
    endtask

    task automatic test_vector();
        logic [7:0] exp_ctl;
        b.EsVecID = 1'b1;
        for (int g = 0; g < 5; g++) begin
            #1;
            exp_ctl = (g == 0) ? 8'b1100_0100 : (g < 4) ? 8'b1100_0101 : 8'b0000_0111;
            n_checks++;
            if (ctl !== exp_ctl || b.VecIdx !== 5'(g * 5) || b.VecLanes !== 3'd5) begin
                n_fail++; $display("FAIL vector_group%0d: got ctl=%b idx=%0d lanes=%0d expected %b/%0d/5",
                                   g, ctl, b.VecIdx, b.VecLanes, exp_ctl, g * 5);
            end
            tick();
        end
        b.EsVecID = 1'b0;
        #1;
        n_checks++;
        if (ctl !== 8'h00 || b.VecIdx !== 5'd0) begin
            n_fail++; $display("FAIL vector_done: got ctl=%b idx=%0d expected 00000000/0", ctl, b.VecIdx);
        end
    endtask

    task automatic test_partial();
        b4.EsVecID = 1'b1;
        for (int g = 0; g < 7; g++) begin
            #1;
            n_checks++;
            if (b4.VecIdx !== 5'(g * 4) || b4.VecLanes !== ((g == 6) ? 3'd1 : 3'd4) ||
                b4.VecUltimo !== (g == 6) || b4.VecValido !== 1'b1 || b4.StallFD !== (g != 6)) begin
                n_fail++; $display("FAIL partial_group%0d: got idx=%0d lanes=%0d ult=%b fd=%b",
                                   g, b4.VecIdx, b4.VecLanes, b4.VecUltimo, b4.StallFD);
            end
            tick();
            b4.EsVecID = 1'b0;
        end
        #1;
        n_checks++;
        if (ctl4 !== 8'h00) begin
            n_fail++; $display("FAIL partial_done: got %b expected %b", ctl4, 8'h00);
        end
    endtask

    task automatic test_branch_abort();
        b.EsVecID = 1'b1;
        tick();
        b.EsVecID = 1'b0;
        tick();
        b.SaltoEX = 1'b1;
        #1;
        n_checks++;
        if (ctl !== 8'b0001_1001 || b.VecIdx !== 5'd10) begin
            n_fail++; $display("FAIL branch_flush: got ctl=%b idx=%0d expected 00011001/10", ctl, b.VecIdx);
        end
        tick();
        b.SaltoEX = 1'b0;
        #1;
        n_checks++;
        if (ctl !== 8'h00 || b.VecIdx !== 5'd0) begin
            n_fail++; $display("FAIL branch_run: got ctl=%b idx=%0d expected 00000000/0", ctl, b.VecIdx);
        end
    endtask

    task automatic test_stallext();
        b.EsVecID = 1'b1;
        tick();
        b.EsVecID = 1'b0;
        tick();
        tick();
        b.StallExt = 1'b1; b.SaltoEX = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++;
            if (ctl !== 8'b1110_0101 || b.VecIdx !== 5'd15) begin
                n_fail++; $display("FAIL stallext_cycle%0d: got ctl=%b idx=%0d expected 11100101/15",
                                   k, ctl, b.VecIdx);
            end
            tick();
        end
        b.StallExt = 1'b0; b.SaltoEX = 1'b0;
        #1;
        n_checks++;
        if (ctl !== 8'b1100_0101 || b.VecIdx !== 5'd15) begin
            n_fail++; $display("FAIL stallext_resume: got ctl=%b idx=%0d expected 11000101/15", ctl, b.VecIdx);
        end
        tick();
        n_checks++;
        if (ctl !== 8'b0000_0111 || b.VecIdx !== 5'd20) begin
            n_fail++; $display("FAIL stallext_last: got ctl=%b idx=%0d expected 00000111/20", ctl, b.VecIdx);
        end
        tick();
        n_checks++;
        if (ctl !== 8'h00) begin
            n_fail++; $display("FAIL stallext_done: got %b expected %b", ctl, 8'h00);
        end
    endtask

    task automatic test_async_reset();
        b.EsVecID = 1'b1;
        tick();
        b.EsVecID = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (ctl !== 8'h00 || b.VecIdx !== 5'd0 || b.VecLanes !== 3'd0) begin
            n_fail++; $display("FAIL async_reset: got ctl=%b idx=%0d lanes=%0d expected 0/0/0",
                               ctl, b.VecIdx, b.VecLanes);
        end
        #2;
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (b.Ocupado !== 1'b0 || b.VecIdx !== 5'd0 || ctl !== 8'h00) begin
            n_fail++; $display("FAIL after_async_reset: got ctl=%b idx=%0d expected 00000000/0", ctl, b.VecIdx);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_load_use();
        test_hazard_vs_vector();
        test_vector();
        test_partial();
        test_branch_abort();
        test_stallext();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
